// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Brief    : Data RAM plus an MMIO page (compare timer, output FIFO) behind
//            the single-cycle core's combinational load / clocked store port.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq
);

  localparam int                   c_ram_aw    = $clog2(RAM_WORDS);
  localparam int                   c_fifo_pw   = $clog2(FIFO_DEPTH);
  localparam int                   c_fifo_cw   = c_fifo_pw + 1;
  localparam logic [c_fifo_cw-1:0] c_fifo_full = c_fifo_cw'(FIFO_DEPTH);
  localparam logic [29:0]          c_base_w    = MMIO_BASE[31:2];

  // --------------------------------------------------------------------------
  // Address decode (word granularity)
  // --------------------------------------------------------------------------
  logic [29:0]         w_word;
  logic [c_ram_aw-1:0] w_ram_idx;
  logic                w_in_ram;
  logic                w_sel_count, w_sel_cmp, w_sel_ctrl, w_sel_status, w_sel_out;
  logic                w_sel_any, w_bad_access;
  logic                w_wr_count, w_wr_cmp, w_wr_ctrl, w_wr_status;
  logic                w_unused_addr;

  assign w_word       = addr[31:2];
  assign w_ram_idx    = addr[c_ram_aw+1:2];
  assign w_in_ram     = (addr[31:c_ram_aw+2] == '0);
  assign w_sel_count  = (w_word == c_base_w);
  assign w_sel_cmp    = (w_word == c_base_w + 30'd1);
  assign w_sel_ctrl   = (w_word == c_base_w + 30'd2);
  assign w_sel_status = (w_word == c_base_w + 30'd3);
  assign w_sel_out    = (w_word == c_base_w + 30'd4);
  assign w_sel_any    = w_sel_count | w_sel_cmp | w_sel_ctrl | w_sel_status | w_sel_out;
  assign w_bad_access = (MemRead | MemWrite) & ~(w_in_ram | w_sel_any);
  assign w_unused_addr = ^addr[1:0];

  assign w_wr_count  = MemWrite & w_sel_count;
  assign w_wr_cmp    = MemWrite & w_sel_cmp;
  assign w_wr_ctrl   = MemWrite & w_sel_ctrl;
  assign w_wr_status = MemWrite & w_sel_status;

  // --------------------------------------------------------------------------
  // Data RAM: asynchronous read, contents survive reset
  // --------------------------------------------------------------------------
  logic [31:0] r_ram [RAM_WORDS];

  // A store presented while reset is held is discarded.
  always_ff @(posedge clk) begin
    if (reset && MemWrite && w_in_ram) begin
      r_ram[w_ram_idx] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [31:0]          r_fifo_mem [FIFO_DEPTH];
  logic [c_fifo_pw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_fifo_cw-1:0] r_fifo_cnt, w_fifo_cnt_nxt;
  logic                 w_full, w_empty, w_push, w_pop, w_push_ok;
  logic [31:0]          w_cnt_ext;
  logic [2:0]           w_cnt_sat;

  assign w_full    = (r_fifo_cnt == c_fifo_full);
  assign w_empty   = (r_fifo_cnt == '0);
  assign w_push    = MemWrite & w_sel_out;
  assign w_pop     = out_valid & out_ready;
  // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_cnt_ext = 32'(r_fifo_cnt);
  assign w_cnt_sat = (w_cnt_ext > 32'd7) ? 3'd7 : w_cnt_ext[2:0];

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? 32'd0 : r_fifo_mem[r_rd_ptr];

  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt;
    case ({w_push_ok, w_pop})
      2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + 1'b1;
      2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - 1'b1;
      default: w_fifo_cnt_nxt = r_fifo_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_cnt <= w_fifo_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Compare timer and sticky status flags
  // --------------------------------------------------------------------------
  logic [31:0] r_count, r_cmp, w_count_nxt;
  logic [2:0]  r_ctrl;
  logic        r_tflag, r_ovf, r_badaddr, r_irq;
  logic        w_hit, w_tflag_nxt, w_ovf_nxt, w_badaddr_nxt;

  assign w_hit = r_ctrl[0] & (r_count == r_cmp);
  assign irq   = r_irq;

  // Flag sets are applied after W1C clears so a same-cycle event is never lost.
  always_comb begin
    w_count_nxt = r_count;
    if (r_ctrl[0]) begin
      w_count_nxt = (w_hit && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
    end
    if (w_wr_count) w_count_nxt = wdata;

    w_tflag_nxt = r_tflag;
    if (w_wr_status && wdata[0]) w_tflag_nxt = 1'b0;
    if (w_hit)                   w_tflag_nxt = 1'b1;

    w_ovf_nxt = r_ovf;
    if (w_wr_status && wdata[3])      w_ovf_nxt = 1'b0;
    if (w_push && w_full && !w_pop)   w_ovf_nxt = 1'b1;

    w_badaddr_nxt = r_badaddr;
    if (w_wr_status && wdata[4]) w_badaddr_nxt = 1'b0;
    if (w_bad_access)            w_badaddr_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= 32'd0;
      r_cmp     <= 32'hFFFF_FFFF;
      r_ctrl    <= 3'd0;
      r_tflag   <= 1'b0;
      r_ovf     <= 1'b0;
      r_badaddr <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      if (w_wr_cmp)  r_cmp  <= wdata;
      if (w_wr_ctrl) r_ctrl <= wdata[2:0];
      r_tflag   <= w_tflag_nxt;
      r_ovf     <= w_ovf_nxt;
      r_badaddr <= w_badaddr_nxt;
      r_irq     <= r_tflag & r_ctrl[2];
    end
  end

  // --------------------------------------------------------------------------
  // Load data mux (zero whenever no load is requested)
  // --------------------------------------------------------------------------
  logic [31:0] w_status;

  assign w_status = {24'd0, w_cnt_sat, r_badaddr, r_ovf, w_empty, w_full, r_tflag};

  always_comb begin
    rdata = 32'd0;
    if (MemRead) begin
      if (w_in_ram)          rdata = r_ram[w_ram_idx];
      else if (w_sel_count)  rdata = r_count;
      else if (w_sel_cmp)    rdata = r_cmp;
      else if (w_sel_ctrl)   rdata = {29'd0, r_ctrl};
      else if (w_sel_status) rdata = w_status;
      else                   rdata = 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Brief    : Self-checking bench with a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

  localparam int          RW = 64;
  localparam int          FD = 4;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0, reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, out_ready = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata, out_data;
  logic        out_valid, irq;

  dmem_mmio_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_ram [RW];
  bit          m_known [RW];
  logic [31:0] m_count, m_cmp;
  logic [2:0]  m_ctrl;
  bit          m_tflag, m_ovf, m_bad, m_irq;
  logic [31:0] m_fifo [$];

  function automatic int m_reg(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w >= MB && (w - MB) <= 32'd16) return int'((w - MB) >> 2);
    return -1;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    int sat;
    n   = m_fifo.size();
    sat = (n > 7) ? 7 : n;
    return (32'(sat) << 5) | (32'(m_bad) << 4) | (32'(m_ovf) << 3) |
           (32'(n == 0) << 2) | (32'(n == FD) << 1) | 32'(m_tflag);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'(4 * RW)) return m_ram[int'(a >> 2)];
    case (m_reg(a))
      0:       return m_count;
      1:       return m_cmp;
      2:       return {29'd0, m_ctrl};
      3:       return m_status();
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_checkable(input logic [31:0] a);
    if (a < 32'(4 * RW)) return m_known[int'(a >> 2)];
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 3'd0;
    m_tflag = 0; m_ovf = 0; m_bad = 0; m_irq = 0;
    m_fifo.delete();
  endtask

  // One clock edge of the architectural behaviour, using the current inputs.
  task automatic m_step();
    int          r;
    int          n;
    bit          ram, pop, push, full, hit, w1c;
    logic [31:0] nc;
    r    = m_reg(addr);
    ram  = (addr < 32'(4 * RW));
    n    = m_fifo.size();
    pop  = (n > 0) && out_ready;
    push = MemWrite && (r == 4);
    full = (n == FD);
    hit  = m_ctrl[0] && (m_count == m_cmp);
    w1c  = MemWrite && (r == 3);
    m_irq = m_tflag & m_ctrl[2];
    nc = m_count;
    if (m_ctrl[0]) nc = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (MemWrite && r == 0) nc = wdata;
    m_count = nc;
    if (w1c && wdata[0]) m_tflag = 0;
    if (hit) m_tflag = 1;
    if (w1c && wdata[3]) m_ovf = 0;
    if (push && full && !pop) m_ovf = 1;
    if (w1c && wdata[4]) m_bad = 0;
    if ((MemRead || MemWrite) && !ram && r < 0) m_bad = 1;
    if (MemWrite && r == 1) m_cmp = wdata;
    if (MemWrite && r == 2) m_ctrl = wdata[2:0];
    if (pop) void'(m_fifo.pop_front());
    if (push && (!full || pop)) m_fifo.push_back(wdata);
    if (MemWrite && ram) begin
      m_ram[int'(addr >> 2)]   = wdata;
      m_known[int'(addr >> 2)] = 1'b1;
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    MemRead = mr; MemWrite = mw; addr = a; wdata = wd; out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_step();
    else m_reset();
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    m_reset();
    drive(0, 0, 32'd0, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata_idle: got %h want 0", rdata); end
    drive(1, 0, MB, 32'd0, 0);
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h want 0", rdata); end
    drive(1, 0, MB + 32'h4, 32'd0, 0);
    n_cmp++; if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp: got %h want ffffffff", rdata); end
    drive(1, 0, MB + 32'h8, 32'd0, 0);
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", rdata); end
    drive(1, 0, MB + 32'hC, 32'd0, 0);
    n_cmp++; if (rdata !== 32'h4) begin n_bad++; $display("FAIL reset_status: got %h want 4", rdata); end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 32'd0, 32'd0, 0);
    tick();
  endtask

  task automatic test_ram();
    int          idx [$];
    logic [31:0] a, exp, v;
    drive(0, 1, 32'h40, 32'hDEAD_BEEF, 0); tick();
    drive(1, 0, 32'h40, 32'd0, 0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_load_40: got %h want deadbeef", rdata); end
    drive(1, 0, 32'h42, 32'd0, 0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_load_42: got %h want deadbeef", rdata); end
    for (int i = 0; i < 12; i++) begin
      a = 32'($urandom_range(0, RW - 1)) << 2;
      idx.push_back(int'(a >> 2));
      drive(0, 1, a | 32'($urandom_range(0, 3)), $urandom, 0); tick();
    end
    for (int i = 0; i < 12; i++) begin
      a = (32'(idx[i]) << 2) | 32'($urandom_range(0, 3));
      drive(1, 0, a, 32'd0, 0);
      exp = m_read(a);
      n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL ram_rand_load a=%h: got %h want %h", a, rdata, exp); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'(idx[i]) << 2;
      v = $urandom;
      drive(1, 1, a, v, 0);
      exp = m_read(a);
      n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL ram_rw_prewrite a=%h: got %h want %h", a, rdata, exp); end
      tick();
      drive(1, 0, a, 32'd0, 0);
      n_cmp++; if (rdata !== v) begin n_bad++; $display("FAIL ram_rw_after a=%h: got %h want %h", a, rdata, v); end
    end
  endtask

  task automatic test_timer();
    logic [31:0] exp;
    drive(0, 1, MB + 32'h4, 32'd5, 0); tick();
    drive(0, 1, MB, 32'd0, 0);         tick();
    drive(0, 1, MB + 32'h8, 32'h7, 0); tick();
    for (int i = 0; i < 14; i++) begin
      if (i == 8)      drive(0, 1, MB + 32'hC, 32'h1, 0);
      else if (i == 7) drive(1, 0, MB + 32'hC, 32'd0, 0);
      else             drive(1, 0, MB, 32'd0, 0);
      exp = MemRead ? m_read(addr) : 32'd0;
      n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL timer_read i=%0d: got %h want %h", i, rdata, exp); end
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL timer_irq i=%0d: got %b want %b", i, irq, m_irq); end
      if (i == 5) begin n_cmp++; if (rdata !== 32'd5) begin n_bad++; $display("FAIL timer_count5: got %h want 5", rdata); end end
      if (i == 6) begin n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL timer_reload: got %h want 0", rdata); end end
      if (i == 7) begin
        n_cmp++; if (rdata[0] !== 1'b1) begin n_bad++; $display("FAIL timer_tflag: got %b want 1", rdata[0]); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL timer_irq_rise: got %b want 1", irq); end
      end
      if (i == 10) begin n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL timer_irq_clear: got %b want 0", irq); end end
      tick();
    end
    // Free-running wrap without autoreload
    drive(0, 1, MB + 32'h8, 32'h0, 0);         tick();
    drive(0, 1, MB + 32'h4, 32'd3, 0);         tick();
    drive(0, 1, MB, 32'hFFFF_FFFE, 0);         tick();
    drive(0, 1, MB + 32'h8, 32'h1, 0);         tick();
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, MB, 32'd0, 0);
      exp = m_read(MB);
      n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL wrap_count j=%0d: got %h want %h", j, rdata, exp); end
      if (j == 2) begin n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL wrap_zero: got %h want 0", rdata); end end
      if (j == 6) begin n_cmp++; if (rdata !== 32'd4) begin n_bad++; $display("FAIL noreload_past_cmp: got %h want 4", rdata); end end
      tick();
    end
    drive(0, 1, MB + 32'h8, 32'h0, 0);  tick();
    drive(0, 1, MB + 32'hC, 32'h19, 0); tick();
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] exp;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, MB + 32'h10, 32'(k), 0); tick();
    end
    drive(1, 0, MB + 32'hC, 32'd0, 0);
    exp = m_read(MB + 32'hC);
    n_cmp++; if (rdata !== 32'h8A) begin n_bad++; $display("FAIL ovf_status: got %h want 8a", rdata); end
    n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL ovf_status_model: got %h want %h", rdata, exp); end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 32'd0, 32'd0, 1);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid k=%0d: got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== 32'(k)) begin n_bad++; $display("FAIL drain_data k=%0d: got %h want %h", k, out_data, 32'(k)); end
      tick();
    end
    drive(0, 0, 32'd0, 32'd0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL drain_empty_data: got %h want 0", out_data); end
    drive(0, 1, MB + 32'hC, 32'h8, 0); tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 5; k <= 8; k++) begin
      drive(0, 1, MB + 32'h10, 32'(k), 0); tick();
    end
    drive(0, 1, MB + 32'h10, 32'd9, 1);
    n_cmp++; if (out_data !== 32'd5) begin n_bad++; $display("FAIL full_pushpop_head: got %h want 5", out_data); end
    tick();
    drive(1, 0, MB + 32'hC, 32'd0, 0);
    n_cmp++; if (rdata !== 32'h82) begin n_bad++; $display("FAIL full_pushpop_status: got %h want 82", rdata); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 32'd0, 32'd0, 1);
      n_cmp++; if (out_data !== 32'(6 + k)) begin n_bad++; $display("FAIL full_pushpop_drain k=%0d: got %h want %h", k, out_data, 32'(6 + k)); end
      tick();
    end
    drive(0, 1, MB + 32'h10, 32'h77, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL empty_pushpop_pre: got %b want 0", out_valid); end
    tick();
    drive(0, 0, 32'd0, 32'd0, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin n_bad++; $display("FAIL empty_pushpop_post: got %b/%h want 1/77", out_valid, out_data); end
    tick();
    drive(0, 0, 32'd0, 32'd0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL empty_pushpop_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    int          k, r;
    logic [31:0] a, wd, exp;
    logic        mr, mw, rdy;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      r = -1;
      if (k <= 3) begin
        a = (32'($urandom_range(0, RW - 1)) << 2) | 32'($urandom_range(0, 3));
      end else if (k <= 7) begin
        r = $urandom_range(0, 4);
        a = MB + (32'(r) << 2) + 32'($urandom_range(0, 3));
      end else if (k == 8) begin
        a = 32'h0001_0000 + ($urandom & 32'h0FFF_FFFC);
      end else begin
        a = MB + 32'h14 + (32'($urandom_range(0, 50)) << 2);
      end
      wd  = (r == 0 || r == 1) ? 32'($urandom_range(0, 12)) : $urandom;
      mr  = ($urandom_range(0, 1) == 1);
      mw  = ($urandom_range(0, 4) < 2);
      rdy = ($urandom_range(0, 2) != 0);
      drive(mr, mw, a, wd, rdy);
      exp = mr ? m_read(a) : 32'd0;
      if (!mr || m_checkable(a)) begin
        n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL rand_rdata i=%0d a=%h: got %h want %h", i, a, rdata, exp); end
      end
      n_cmp++; if (out_valid !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL rand_valid i=%0d: got %b", i, out_valid); end
      exp = (m_fifo.size() != 0) ? m_fifo[0] : 32'd0;
      n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL rand_out_data i=%0d: got %h want %h", i, out_data, exp); end
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq i=%0d: got %b want %b", i, irq, m_irq); end
      tick();
    end
  endtask

  task automatic test_badaddr_reset();
    drive(1, 0, 32'h8000_0000, 32'd0, 0);
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL bad_rdata: got %h want 0", rdata); end
    tick();
    drive(1, 0, MB + 32'hC, 32'd0, 0);
    n_cmp++; if (rdata[4] !== 1'b1) begin n_bad++; $display("FAIL bad_flag: got %b want 1", rdata[4]); end
    drive(0, 1, MB + 32'h4, 32'h55, 0);     tick();
    drive(0, 1, MB, 32'h1234, 0);           tick();
    drive(0, 1, MB + 32'h8, 32'h1, 0);      tick();
    drive(0, 1, 32'h80, 32'hA5A5_0001, 0);  tick();
    drive(0, 1, MB + 32'h10, 32'h11, 0);    tick();
    drive(0, 1, MB + 32'h10, 32'h22, 0);    tick();
    drive(0, 0, 32'd0, 32'd0, 1);           tick();
    drive(0, 1, 32'h80, 32'hBAD0_BAD0, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL middrain_valid: got %b want 1", out_valid); end
    reset = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL async_rst_data: got %h want 0", out_data); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_rst_irq: got %b want 0", irq); end
    tick();
    drive(1, 0, MB, 32'd0, 0);
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL async_rst_count: got %h want 0", rdata); end
    drive(1, 0, MB + 32'h4, 32'd0, 0);
    n_cmp++; if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL async_rst_cmp: got %h want ffffffff", rdata); end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 32'd0, 32'd0, 0);
    tick();
    drive(1, 0, 32'h80, 32'd0, 0);
    n_cmp++; if (rdata !== 32'hA5A5_0001) begin n_bad++; $display("FAIL rst_write_lost: got %h want a5a50001", rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < RW; i++) m_known[i] = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    test_badaddr_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
